// File: rtl/hs_activity_monitor.sv
// hs_activity_monitor: per-channel ap_ctrl handshake tracker with saturating
// activity counters and a registered counter read port.

// One monitored channel: transaction FSM plus its eight counters.
module hs_am_lane #(
  parameter int CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   hold,
  input  logic                   start,
  input  logic                   ready,
  input  logic                   done,
  input  logic                   cont,
  output logic                   busy,
  output logic [7:0][CNT_W-1:0]  cnt
);
  typedef enum logic [1:0] {IDLE, BUSY, WAIT_CONT} st_t;

  st_t              st, st_nxt;
  logic [CNT_W-1:0] starts, dones, readies, busyc, lastl, maxl, stallc, minl;
  logic [CNT_W-1:0] lat_cnt, lat_nxt, lat_l;
  logic             ev_start, ev_busy, ev_stall, ev_done;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  // Next state and per-cycle events; completion latency in lat_l.
  always_comb begin
    st_nxt   = st;
    lat_nxt  = lat_cnt;
    lat_l    = '0;
    ev_start = 1'b0;
    ev_busy  = 1'b0;
    ev_stall = 1'b0;
    ev_done  = 1'b0;
    case (st)
      IDLE: if (start) begin
        ev_start = 1'b1;
        ev_busy  = 1'b1;
        if (done) begin
          ev_done = 1'b1;
          lat_l   = CNT_W'(1);
          st_nxt  = cont ? IDLE : WAIT_CONT;
        end else begin
          lat_nxt = CNT_W'(1);
          st_nxt  = BUSY;
        end
      end
      BUSY: begin
        ev_busy = 1'b1;
        if (done) begin
          ev_done = 1'b1;
          lat_l   = sat_inc(lat_cnt);
          st_nxt  = cont ? IDLE : WAIT_CONT;
        end else begin
          lat_nxt = sat_inc(lat_cnt);
        end
      end
      WAIT_CONT: begin
        ev_stall = 1'b1;
        if (cont) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // State and counter registers; clear wins over hold, hold freezes all.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st <= IDLE; lat_cnt <= '0;
      starts <= '0; dones <= '0; readies <= '0; busyc <= '0;
      lastl <= '0; maxl <= '0; stallc <= '0; minl <= '1;
    end else if (clr) begin
      st <= IDLE; lat_cnt <= '0;
      starts <= '0; dones <= '0; readies <= '0; busyc <= '0;
      lastl <= '0; maxl <= '0; stallc <= '0; minl <= '1;
    end else if (!hold) begin
      st      <= st_nxt;
      lat_cnt <= lat_nxt;
      if (ready)    readies <= sat_inc(readies);
      if (ev_start) starts  <= sat_inc(starts);
      if (ev_busy)  busyc   <= sat_inc(busyc);
      if (ev_stall) stallc  <= sat_inc(stallc);
      if (ev_done) begin
        dones <= sat_inc(dones);
        lastl <= lat_l;
        if (lat_l > maxl) maxl <= lat_l;
        if (lat_l < minl) minl <= lat_l;
      end
    end
  end

  assign busy = (st != IDLE);
  assign cnt  = {minl, stallc, maxl, lastl, busyc, readies, dones, starts};
endmodule

// Top: lane array, sticky freeze flag and the registered read mux.
module hs_activity_monitor #(
  parameter int NUM_CH = 7,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              finish,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [NUM_CH-1:0] ch_busy,
  output logic              frozen
);
  localparam int          NSLOT = 1 << CH_W;
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [2:0]      sel;
  } rd_req_t;

  rd_req_t                         req;
  logic                            oor;
  logic                            hold;
  logic [NSLOT-1:0][7:0][CNT_W-1:0] cnt_all;

  // The edge that first sees finish is already excluded from counting.
  assign hold = frozen | finish;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_lane
      hs_am_lane #(.CNT_W(CNT_W)) u_lane (
        .clock (clock),
        .reset (reset),
        .clr   (clear),
        .hold  (hold),
        .start (ap_start[g]),
        .ready (ap_ready[g]),
        .done  (ap_done[g]),
        .cont  (ap_continue[g]),
        .busy  (ch_busy[g]),
        .cnt   (cnt_all[g])
      );
    end
    // Unused channel slots read as zero so the mux index is always legal.
    for (g = NUM_CH; g < NSLOT; g++) begin : g_pad
      assign cnt_all[g] = '0;
    end
  endgenerate

  // Sticky freeze; clear overrides a simultaneous finish.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)       frozen <= 1'b0;
    else if (clear)  frozen <= 1'b0;
    else if (finish) frozen <= 1'b1;
  end

  assign req = '{ch: rd_ch, sel: rd_sel};
  assign oor = ({1'b0, req.ch} >= NCH);

  // Registered read; samples pre-update counter values, data holds when idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en & oor;
      if (rd_en) rd_data <= oor ? '0 : cnt_all[req.ch][req.sel];
    end
  end
endmodule

// File: tb/tb_hs_activity_monitor.sv
// Scoreboard bench for hs_activity_monitor: directed handshake scenarios and
// random traffic against a transaction-level reference model.
module tb_hs_activity_monitor;
  localparam int NCH  = 7;
  localparam int W    = 8;
  localparam int SATV = (1 << W) - 1;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] ap_start = '0, ap_ready = '0, ap_done = '0, ap_continue = '1;
  logic           finish = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic [2:0]     rd_ch = '0, rd_sel = '0;
  logic [W-1:0]   rd_data;
  logic           rd_valid, rd_err, frozen;
  logic [NCH-1:0] ch_busy;

  hs_activity_monitor #(.NUM_CH(NCH), .CNT_W(W)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
    .clear(clear), .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
    .ch_busy(ch_busy), .frozen(frozen)
  );

  always #5 clock = ~clock;

  typedef struct { int d; bit e; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;

  // Reference model: unbounded counts, saturation applied when read.
  int m_starts[NCH], m_dones[NCH], m_ready[NCH], m_busy[NCH], m_stall[NCH];
  int m_last[NCH], m_max[NCH], m_min[NCH], m_age[NCH];
  bit m_act[NCH], m_wait[NCH];
  bit m_frozen;

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(int x);
    return (x > SATV) ? SATV : x;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_starts[c] = 0; m_dones[c] = 0; m_ready[c] = 0; m_busy[c] = 0;
      m_stall[c] = 0; m_last[c] = 0; m_max[c] = 0; m_min[c] = 1 << 30;
      m_age[c] = 0; m_act[c] = 0; m_wait[c] = 0;
    end
    m_frozen = 0;
  endtask

  task automatic m_complete(int c, int lat);
    m_dones[c]++;
    m_last[c] = lat;
    if (lat > m_max[c]) m_max[c] = lat;
    if (lat < m_min[c]) m_min[c] = lat;
    m_act[c]  = 0;
    m_wait[c] = !ap_continue[c];
  endtask

  task automatic m_update();
    if (clear) m_reset();
    else if (m_frozen || finish) begin
      if (finish) m_frozen = 1;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (ap_ready[c]) m_ready[c]++;
        if (m_wait[c]) begin
          m_stall[c]++;
          if (ap_continue[c]) m_wait[c] = 0;
        end else if (m_act[c]) begin
          m_busy[c]++;
          m_age[c]++;
          if (ap_done[c]) m_complete(c, m_age[c]);
        end else if (ap_start[c]) begin
          m_starts[c]++;
          m_busy[c]++;
          m_age[c] = 1;
          m_act[c] = 1;
          if (ap_done[c]) m_complete(c, 1);
        end
      end
    end
  endtask

  function automatic exp_t m_read(int c, int s);
    exp_t r;
    r.e = (c >= NCH);
    r.d = 0;
    if (!r.e) begin
      case (s)
        0: r.d = sat(m_starts[c]);
        1: r.d = sat(m_dones[c]);
        2: r.d = sat(m_ready[c]);
        3: r.d = sat(m_busy[c]);
        4: r.d = sat(m_last[c]);
        5: r.d = sat(m_max[c]);
        6: r.d = sat(m_stall[c]);
        default: r.d = sat(m_min[c]);
      endcase
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] m_busyv();
    logic [NCH-1:0] v;
    for (int c = 0; c < NCH; c++) v[c] = m_act[c] | m_wait[c];
    return v;
  endfunction

  // One clock: model sees the same inputs the DUT samples at this edge.
  task automatic step();
    @(posedge clock);
    if (rd_en) q.push_back(m_read(rd_ch, rd_sel));
    m_update();
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Read with a hand-derived expected value instead of the model's.
  task automatic rd_const(int c, int s, int d, bit e);
    exp_t x;
    rd_en = 1; rd_ch = 3'(c); rd_sel = 3'(s);
    @(posedge clock);
    x.d = d; x.e = e;
    q.push_back(x);
    m_update();
    #1;
    rd_en = 0;
  endtask

  // Monitor: pops the scoreboard whenever the read port presents data.
  always @(negedge clock) begin
    if (!reset) begin
      if (rd_valid) begin
        if (q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          exp_t x;
          x = q.pop_front();
          chk("rd_data", rd_data, x.d);
          chk("rd_err", rd_err, x.e);
        end
      end else begin
        if (q.size() != 0) begin
          chk("rd_missing", 0, 1);
          void'(q.pop_front());
        end
        chk("rd_err_idle", rd_err, 0);
      end
      chk("ch_busy", ch_busy, m_busyv());
      chk("frozen", frozen, m_frozen);
    end
  end

  initial begin
    m_reset();
    repeat (3) @(posedge clock);
    #1 reset = 0;

    // Reset values of every counter of channel 0, plus out-of-range channel.
    for (int s = 0; s < 8; s++) rd_const(0, s, (s == 7) ? SATV : 0, 0);
    rd_const(NCH, 0, 0, 1);

    // ch0: start, done five cycles later, continue high.
    ap_start[0] = 1; step(); ap_start[0] = 0;
    steps(4);
    ap_done[0] = 1; step(); ap_done[0] = 0;
    rd_const(0, 0, 1, 0); rd_const(0, 1, 1, 0); rd_const(0, 3, 6, 0);
    rd_const(0, 4, 6, 0); rd_const(0, 5, 6, 0); rd_const(0, 7, 6, 0);
    rd_const(0, 6, 0, 0);

    // ch3: same-cycle start+done, then latency 4 with three stall cycles.
    ap_start[3] = 1; ap_done[3] = 1; step();
    ap_done[3] = 0; step();
    ap_start[3] = 0; steps(2);
    ap_done[3] = 1; ap_continue[3] = 0; step();
    ap_done[3] = 0; steps(2);
    ap_continue[3] = 1; step();
    rd_const(3, 7, 1, 0); rd_const(3, 5, 4, 0); rd_const(3, 4, 4, 0);
    rd_const(3, 6, 3, 0); rd_const(3, 1, 2, 0); rd_const(3, 3, 5, 0);

    // ch1: ready-only traffic.
    for (int i = 0; i < 10; i++) begin
      ap_ready[1] = 1; step(); ap_ready[1] = 0; step();
    end
    rd_const(1, 2, 10, 0); rd_const(1, 0, 0, 0);

    // ch4: freeze mid-transaction, then traffic that must not count.
    ap_start[4] = 1; step(); ap_start[4] = 0;
    steps(2);
    finish = 1; step(); finish = 0;
    for (int i = 0; i < 20; i++) begin
      ap_ready = '1; ap_done[4] = 1; step(); ap_ready = '0; ap_done[4] = 0; step();
    end
    rd_const(4, 0, 1, 0); rd_const(4, 3, 3, 0); rd_const(4, 2, 0, 0);
    rd_const(4, 1, 0, 0); rd_const(1, 2, 10, 0); rd_const(0, 3, 6, 0);
    clear = 1; finish = 1; step(); clear = 0; finish = 0;
    rd_const(4, 7, SATV, 0); rd_const(4, 0, 0, 0); rd_const(4, 3, 0, 0);

    // Saturation: ch0 busy for 300 cycles.
    ap_start[0] = 1; step(); ap_start[0] = 0;
    steps(300);
    ap_done[0] = 1; step(); ap_done[0] = 0;
    rd_const(0, 3, SATV, 0); rd_const(0, 4, SATV, 0); rd_const(0, 5, SATV, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        ap_start[c]    = ($urandom_range(2) == 0);
        ap_ready[c]    = $urandom_range(1);
        ap_done[c]     = ($urandom_range(3) == 0);
        ap_continue[c] = ($urandom_range(3) != 0);
      end
      finish = ($urandom_range(399) == 0);
      clear  = ($urandom_range(249) == 0);
      rd_en  = $urandom_range(1);
      rd_ch  = 3'($urandom_range(7));
      rd_sel = 3'($urandom_range(7));
      step();
    end
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    finish = 0; rd_en = 0;
    clear = 1; step(); clear = 0;

    // Async reset in the middle of a frozen BUSY transaction.
    ap_start[2] = 1; step(); ap_start[2] = 0;
    steps(3);
    finish = 1; step(); finish = 0;
    rd_const(2, 0, 1, 0);
    step();
    #1 reset = 1;
    #1;
    chk("rst_ch_busy", ch_busy, 0);
    chk("rst_frozen", frozen, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_rd_data", rd_data, 0);
    #1 reset = 0;
    m_reset();
    q.delete();
    for (int s = 0; s < 8; s++) rd_const(2, s, (s == 7) ? SATV : 0, 0);
    ap_start[2] = 1; ap_done[2] = 1; step(); ap_start[2] = 0; ap_done[2] = 0;
    rd_const(2, 4, 1, 0);

    steps(2);
    @(negedge clock);
    chk("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hs_activity_monitor.md
# hs_activity_monitor

Synthesisable multi-channel activity monitor for ap_ctrl handshakes (ap_start/ap_ready/ap_done/ap_continue) of HLS-generated submodules such as the layernorm and transpose instances. It is the on-chip successor to the simulation-only status dumpers. It tracks each channel with a per-channel transaction FSM and accumulates saturating counters for transactions, readies, busy and stall cycles, plus last/min/max latency. A registered read port exposes the counters for cosim benches and for debug fabric.

## Interface
- NUM_CH, 7: number of monitored channels (1..32).
- CNT_W, 32: width of every counter and latency register (8..48).
- CH_W, $clog2(NUM_CH) (min 1): width of rd_ch.
- clock, in, 1: sole clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- ap_start, in, NUM_CH: per-channel start (bit i = channel i). Tie to 0 for ready-only channels.
- ap_ready, in, NUM_CH: per-channel ready.
- ap_done, in, NUM_CH: per-channel done.
- ap_continue, in, NUM_CH: per-channel continue. Tie to 1 for non-dataflow modules.
- finish, in, 1: end of run; freezes all counters (sticky).
- clear, in, 1: synchronous clear of all counters, FSMs and freeze.
- rd_en, in, 1: read request.
- rd_ch, in, CH_W: channel to read.
- rd_sel, in, 3: counter select: 0 starts, 1 dones, 2 readies, 3 busy_cycles, 4 last_lat, 5 max_lat, 6 stall_cycles, 7 min_lat.
- rd_data, out, CNT_W: read data.
- rd_valid, out, 1: rd_data valid.
- rd_err, out, 1: rd_ch >= NUM_CH.
- ch_busy, out, NUM_CH: channel FSM not in IDLE.
- frozen, out, 1: freeze flag.

## Operation
- Per-channel FSM states: IDLE, BUSY, WAIT_CONT. All events are sampled at the rising edge.
- **IDLE with ap_start=1:**
  - starts+1 and busy_cycles+1.
  - If ap_done=1 in the same cycle, the transaction completes with latency 1: dones+1, latencies updated, then go to IDLE when ap_continue=1, else WAIT_CONT.
  - Otherwise lat_cnt<=1 and go to BUSY.
- **BUSY:**
  - busy_cycles+1 every cycle.
  - ap_done=0: lat_cnt+1.
  - ap_done=1: completion with latency lat_cnt+1. Next state is IDLE if ap_continue=1, else WAIT_CONT.
  - ap_start is ignored.
- **WAIT_CONT:** stall_cycles+1 every cycle. Go to IDLE on ap_continue=1; that cycle also counts as a stall. ap_start is ignored, including in the exit cycle.
- **Completion:**
  - dones+1 and last_lat<=L.
  - max_lat<=max(max_lat,L).
  - min_lat<=min(min_lat,L).
- readies+1 on every cycle ap_ready=1, in any state.
- **Saturation:** every counter, and lat_cnt, holds at 2^CNT_W-1. It never wraps.
- **finish:**
  - finish=1 sets frozen in the next cycle; frozen stays set until clear or reset.
  - While frozen, no counter, latency register or FSM changes.
  - The cycle in which finish is first sampled is itself not counted.
- **clear:**
  - Sets all counters to 0, min_lat to all-ones, all FSMs to IDLE and frozen to 0.
  - clear beats every simultaneous event, including finish.
- **Read port:**
  - rd_en at edge t presents rd_data/rd_valid/rd_err after that edge, i.e. registered, 1-cycle latency.
  - Reads reflect counter values before any update in the same edge.
  - Out-of-range rd_ch returns rd_data=0 with rd_err=1.
  - rd_en=0 gives rd_valid=0 and rd_err=0; rd_data holds its last value.
- Reads are allowed while frozen and during active channels.

## Timing
- Reset values:
  - All counters, last_lat, max_lat, lat_cnt and rd_data are 0.
  - min_lat is all-ones.
  - FSMs are IDLE; ch_busy, frozen, rd_valid and rd_err are 0.
- Reset asserted mid-transaction returns immediately to reset values. Post-reset handshakes are treated as new.
- ch_busy is registered and goes high in the cycle after the start edge.
- No combinational path from any input to any output.

## Test plan
- **Single transaction:**
  - Stimulus: ch0 ap_start 1 cycle, ap_done 5 cycles later, ap_continue=1.
  - Expect: starts=1, dones=1, busy_cycles=6, last_lat=6, max_lat=6, min_lat=6, stall_cycles=0.
- **Same-cycle done and back-pressure:**
  - Stimulus: ch3 start+done in the same cycle (latency 1), then a second transaction of latency 4 with ap_continue low for 3 cycles.
  - Expect: min_lat=1, max_lat=4, last_lat=4, stall_cycles=3, dones=2.
- **Ready-only channel:**
  - Stimulus: ch1 ap_start tied 0, ap_ready pulsed 10 times.
  - Expect: readies=10, starts=0, ch_busy[1] stays 0.
- **Freeze:**
  - Stimulus: finish asserted while ch4 is in BUSY, then 20 more ap_ready pulses.
  - Expect: all reads unchanged after freeze; frozen=1; clear returns min_lat=all-ones and frozen=0.
- **Saturation:**
  - Stimulus: CNT_W=8, ch0 BUSY for 300 cycles.
  - Expect: busy_cycles=255, last_lat=255.
- **Read port edges and async reset:**
  - Stimulus: rd_ch=NUM_CH.
  - Expect: rd_err=1, rd_data=0.
  - Stimulus: reset mid-BUSY.
  - Expect: all outputs at reset values before the next edge.
